// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: latches operands on start, then walks a
// DIGIT-bit full-adder slice from LSB to MSB one digit per clock, keeping the
// inter-digit carry in a single flop. Result bits are written in place.

// One bit of the carry chain.
module serial_addsub_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q;
  logic             carry_q;
  logic             sub_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             c_out_q, ovf_q;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic [DIGIT:0]   chain;
  logic             accept, last;

  // Operands may only be taken when no computation is in flight.
  assign accept = start && (state_q != RUN);
  assign last   = (state_q == RUN) && (step_q == LAST);

  // Pick the digit under the cursor; b is inverted here for subtract.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (step_q == SW'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        b_dig = b_q[k*DIGIT +: DIGIT] ^ {DIGIT{sub_q}};
      end
    end
  end

  assign chain[0] = carry_q;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      serial_addsub_fa u_fa (
        .a_i (a_dig[i]),
        .b_i (b_dig[i]),
        .c_i (chain[i]),
        .s_o (s_dig[i]),
        .c_o (chain[i+1])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: DONE can accept a new start directly, so there is no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (step_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch on accept, otherwise retire one digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q  <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub;
      step_q  <= '0;
      // Subtract is a + ~b + 1, so the borrow-in enters inverted.
      carry_q <= sub ? ~c_in : c_in;
    end else if (state_q == RUN) begin
      for (int k = 0; k < STEPS; k++) begin
        if (step_q == SW'(k)) sum_q[k*DIGIT +: DIGIT] <= s_dig;
      end
      carry_q <= chain[DIGIT];
      step_q  <= step_q + SW'(1);
      if (last) begin
        c_out_q <= chain[DIGIT];
        ovf_q   <= chain[DIGIT] ^ chain[DIGIT-1];
      end
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH=8 with DIGIT=1, 4 and 8 side by side.
module tb_serial_addsub;
  logic       clk = 1'b0;
  logic [2:0] rst_r, start_r;
  logic       sub_r, cin_r;
  logic [7:0] a_r, b_r;
  logic [2:0] busy_w, done_w, cout_w, ovf_w;
  logic [7:0] sum_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_r[0]), .start(start_r[0]), .sub(sub_r), .c_in(cin_r),
    .a(a_r), .b(b_r), .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]),
    .c_out(cout_w[0]), .ovf(ovf_w[0]));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_r[1]), .start(start_r[1]), .sub(sub_r), .c_in(cin_r),
    .a(a_r), .b(b_r), .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]),
    .c_out(cout_w[1]), .ovf(ovf_w[1]));
  serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_r[2]), .start(start_r[2]), .sub(sub_r), .c_in(cin_r),
    .a(a_r), .b(b_r), .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]),
    .c_out(cout_w[2]), .ovf(ovf_w[2]));

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl [7];

  function automatic int steps_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 2 : 1;
  endfunction

  function automatic int digit_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 8;
  endfunction

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input logic s, input logic c,
                                input logic [7:0] av, input logic [7:0] bv,
                                output logic [7:0] rs, output logic co,
                                output logic ov);
    logic [7:0] bb;
    int ci, u, sv;
    bb = s ? ~bv : bv;
    ci = ((s ? !c : c) == 1'b1) ? 1 : 0;
    u  = int'(av) + int'(bb) + ci;
    sv = int'($signed(av)) + int'($signed(bb)) + ci;
    rs = u[7:0];
    co = u[8];
    ov = (sv > 127) || (sv < -128);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (DIGIT=%0d): got %0h, expected %0h", nm, digit_of(d), got, exp);
    end
  endtask

  // Pulse start on one DUT and wait (bounded) for done. lat counts edges from
  // the accepting edge (inclusive) to the edge after which done is seen.
  task automatic run_op(input int d, input logic s, input logic c,
                        input logic [7:0] av, input logic [7:0] bv, output int lat);
    sub_r = s; cin_r = c; a_r = av; b_r = bv;
    start_r[d] = 1'b1;
    @(posedge clk); #1;
    start_r[d] = 1'b0;
    sub_r = ~s; a_r = ~av; b_r = ~bv; cin_r = ~c;
    lat = 1;
    while (!done_w[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", d, 32'(done_w[d]), 32'd1);
  endtask

  task automatic chk_result(input string nm, input int d, input logic s,
                            input logic c, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] rs;
    logic co, ov;
    model(s, c, av, bv, rs, co, ov);
    chk({nm, "_sum"},  d, 32'(sum_w[d]),  32'(rs));
    chk({nm, "_cout"}, d, 32'(cout_w[d]), 32'(co));
    chk({nm, "_ovf"},  d, 32'(ovf_w[d]),  32'(ov));
  endtask

  initial begin
    int lat, n;
    logic seen;
    logic [7:0] ra, rb;
    logic rs, rc;
    logic [7:0] held;

    tbl[0] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'h10, 8'h03, 8'h0C, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

    rst_r = '0; start_r = '0; sub_r = 1'b0; cin_r = 1'b0; a_r = '0; b_r = '0;

    // Reset held 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", d, 32'(busy_w[d]), 32'd0);
      chk("rst_done", d, 32'(done_w[d]), 32'd0);
      chk("rst_sum",  d, 32'(sum_w[d]),  32'd0);
      chk("rst_cout", d, 32'(cout_w[d]), 32'd0);
      chk("rst_ovf",  d, 32'(ovf_w[d]),  32'd0);
    end
    rst_r = '1;
    @(posedge clk); #1;

    // Directed vectors with fixed expectations, plus latency.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 7; i++) begin
        run_op(d, tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b, lat);
        chk("vec_sum",  d, 32'(sum_w[d]),  32'(tbl[i].sum));
        chk("vec_cout", d, 32'(cout_w[d]), 32'(tbl[i].cout));
        chk("vec_ovf",  d, 32'(ovf_w[d]),  32'(tbl[i].ovf));
        chk("vec_latency", d, 32'(lat), 32'(steps_of(d) + 1));
      end
    end

    // Random operations against the model.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 30; i++) begin
        ra = 8'($urandom); rb = 8'($urandom);
        rs = 1'($urandom); rc = 1'($urandom);
        run_op(d, rs, rc, ra, rb, lat);
        chk_result("rnd", d, rs, rc, ra, rb);
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); #1;
          chk("idle_done", d, 32'(done_w[d]), 32'd0);
        end
      end
    end

    // Start while busy is ignored (DIGIT=1).
    @(posedge clk); #1;
    sub_r = 1'b0; cin_r = 1'b0; a_r = 8'h12; b_r = 8'h34;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    n = 1;
    repeat (3) begin @(posedge clk); #1; n++; end
    sub_r = 1'b1; cin_r = 1'b1; a_r = 8'hAA; b_r = 8'h55;
    start_r[0] = 1'b1;
    @(posedge clk); #1; n++;
    start_r[0] = 1'b0;
    while (!done_w[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("ign_done_seen", 0, 32'(done_w[0]), 32'd1);
    chk("ign_latency",   0, 32'(n), 32'd9);
    chk("ign_sum",  0, 32'(sum_w[0]),  32'h46);
    chk("ign_cout", 0, 32'(cout_w[0]), 32'd0);
    chk("ign_ovf",  0, 32'(ovf_w[0]),  32'd0);

    // Back-to-back start in the DONE cycle: no IDLE gap.
    sub_r = 1'b1; cin_r = 1'b0; a_r = 8'h80; b_r = 8'h01;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    chk("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
    chk("b2b_done", 0, 32'(done_w[0]), 32'd0);
    n = 1;
    while (!done_w[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_latency", 0, 32'(n), 32'd9);
    chk("b2b_sum",  0, 32'(sum_w[0]),  32'h7F);
    chk("b2b_cout", 0, 32'(cout_w[0]), 32'd1);
    chk("b2b_ovf",  0, 32'(ovf_w[0]),  32'd1);

    // Result held in IDLE until the next start.
    held = sum_w[0];
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", 0, 32'(sum_w[0]), 32'(held));
    chk("hold_busy", 0, 32'(busy_w[0]), 32'd0);

    // Reset 4 cycles into RUN aborts with no done pulse.
    sub_r = 1'b0; cin_r = 1'b1; a_r = 8'h7F; b_r = 8'h00;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_r[0] = 1'b0;
    @(posedge clk); #1;
    rst_r[0] = 1'b1;
    chk("abort_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("abort_done", 0, 32'(done_w[0]), 32'd0);
    chk("abort_sum",  0, 32'(sum_w[0]),  32'd0);
    chk("abort_cout", 0, 32'(cout_w[0]), 32'd0);
    chk("abort_ovf",  0, 32'(ovf_w[0]),  32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_w[0] || busy_w[0]) seen = 1'b1;
    end
    chk("abort_no_done", 0, 32'(seen), 32'd0);
    run_op(0, 1'b0, 1'b0, 8'h3C, 8'h0F, lat);
    chk_result("after_abort", 0, 1'b0, 1'b0, 8'h3C, 8'h0F);
    chk("after_abort_latency", 0, 32'(lat), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
